l2_cache_ctrl: RTL

//  Request-side controller directly upstream of the L2 cache array. Accepts one 64B-line

---
 rtl/l2_ctrl_pkg.sv | 25 ++
 rtl/l2_sat_counter.sv | 25 ++
 rtl/l2_cache_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/l2_ctrl_pkg.sv
// L2 request controller shared definitions: line geometry, address field
// positions and the controller state encoding.
package l2_ctrl_pkg;

    // Geometry of the L2 array: 64B lines, 8K sets, 64-bit byte address.
    localparam int L2_OFFSET_WIDTH = 6;
    localparam int L2_INDEX_WIDTH  = 13;
    localparam int L2_TAG_WIDTH    = 45;
    localparam int L2_DATA_WIDTH   = 512;

    localparam int L2_INDEX_LSB = L2_OFFSET_WIDTH;
    localparam int L2_TAG_LSB   = L2_OFFSET_WIDTH + L2_INDEX_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_HIT_WR    = 3'd2,
        ST_WB_REQ    = 3'd3,
        ST_FILL_REQ  = 3'd4,
        ST_FILL_WAIT = 3'd5,
        ST_INSTALL   = 3'd6,
        ST_RESP      = 3'd7
    } l2_ctrl_state_t;

endpackage

// File: rtl/l2_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module l2_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/l2_cache_ctrl.sv
// Request-side L2 controller: sequences lookup, hit-write, victim writeback,
// fill and install against the array, and tracks hit/miss statistics.
module l2_cache_ctrl
    import l2_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [L2_DATA_WIDTH-1:0]   req_wdata_i,
    output logic                       resp_valid_o,
    output logic [L2_DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                       resp_err_o,
    output logic                       c_enable_o,
    output logic                       c_comp_o,
    output logic                       c_write_o,
    output logic                       c_valid_in_o,
    output logic [L2_TAG_WIDTH-1:0]    c_tag_in_o,
    output logic [L2_INDEX_WIDTH-1:0]  c_index_o,
    output logic [L2_OFFSET_WIDTH-1:0] c_offset_o,
    output logic [L2_DATA_WIDTH-1:0]   c_data_in_o,
    input  logic                       c_hit_i,
    input  logic                       c_valid_i,
    input  logic                       c_dirty_i,
    input  logic                       c_err_i,
    input  logic [L2_TAG_WIDTH-1:0]    c_tag_out_i,
    input  logic [L2_DATA_WIDTH-1:0]   c_data_out_i,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic                       mem_req_write_o,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr_o,
    output logic [L2_DATA_WIDTH-1:0]   mem_req_wdata_o,
    input  logic                       mem_resp_valid_i,
    input  logic [L2_DATA_WIDTH-1:0]   mem_resp_rdata_i,
    output logic [CNT_WIDTH-1:0]       hit_cnt_o,
    output logic [CNT_WIDTH-1:0]       miss_cnt_o
);

    l2_ctrl_state_t             state_q, state_d;
    logic                       req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0]      req_addr_q, req_addr_d;
    logic [L2_DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
    logic [L2_TAG_WIDTH-1:0]    victim_tag_q, victim_tag_d;
    logic [L2_DATA_WIDTH-1:0]   victim_data_q, victim_data_d;
    logic [L2_DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
    logic [L2_DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                       resp_err_q, resp_err_d;

    logic [L2_TAG_WIDTH-1:0]    req_tag;
    logic [L2_INDEX_WIDTH-1:0]  req_index;
    logic [L2_OFFSET_WIDTH-1:0] req_offset;
    logic                       lookup_ok, lookup_hit;

    assign req_tag    = req_addr_q[L2_TAG_LSB +: L2_TAG_WIDTH];
    assign req_index  = req_addr_q[L2_INDEX_LSB +: L2_INDEX_WIDTH];
    assign req_offset = req_addr_q[L2_OFFSET_WIDTH-1:0];

    assign lookup_ok  = (state_q == ST_LOOKUP) && !c_err_i;
    assign lookup_hit = c_hit_i && c_valid_i;

    always_comb begin
        state_d       = state_q;
        req_write_d   = req_write_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        victim_tag_d  = victim_tag_q;
        victim_data_d = victim_data_q;
        fill_data_d   = fill_data_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) begin
                req_write_d = req_write_i;
                req_addr_d  = req_addr_i;
                req_wdata_d = req_wdata_i;
                state_d     = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (c_err_i) begin
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end else if (lookup_hit) begin
                    if (req_write_q) state_d = ST_HIT_WR;
                    else begin
                        resp_rdata_d = c_data_out_i;
                        state_d      = ST_RESP;
                    end
                end else begin
                    // Latch the victim now; the array is overwritten by INSTALL.
                    victim_tag_d  = c_tag_out_i;
                    victim_data_d = c_data_out_i;
                    state_d       = (c_valid_i && c_dirty_i) ? ST_WB_REQ : ST_FILL_REQ;
                end
            end
            ST_HIT_WR:    state_d = ST_RESP;
            ST_WB_REQ:    if (mem_req_ready_i) state_d = ST_FILL_REQ;
            ST_FILL_REQ:  if (mem_req_ready_i) state_d = ST_FILL_WAIT;
            ST_FILL_WAIT: if (mem_resp_valid_i) begin
                fill_data_d = mem_resp_rdata_i;
                state_d     = ST_INSTALL;
            end
            ST_INSTALL:   state_d = ST_LOOKUP;
            ST_RESP: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            req_write_q   <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            fill_data_q   <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_write_q   <= req_write_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            victim_tag_q  <= victim_tag_d;
            victim_data_q <= victim_data_d;
            fill_data_q   <= fill_data_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    assign c_enable_o   = (state_q == ST_LOOKUP) || (state_q == ST_HIT_WR) || (state_q == ST_INSTALL);
    assign c_comp_o     = (state_q == ST_LOOKUP) || (state_q == ST_HIT_WR);
    assign c_write_o    = (state_q == ST_HIT_WR) || (state_q == ST_INSTALL);
    assign c_valid_in_o = (state_q == ST_INSTALL);
    assign c_tag_in_o   = c_enable_o ? req_tag    : '0;
    assign c_index_o    = c_enable_o ? req_index  : '0;
    assign c_offset_o   = c_enable_o ? req_offset : '0;
    assign c_data_in_o  = (state_q == ST_HIT_WR)  ? req_wdata_q :
                          (state_q == ST_INSTALL) ? fill_data_q : '0;

    // Request fields come only from registers, so they hold until accepted.
    assign mem_req_valid_o = (state_q == ST_WB_REQ) || (state_q == ST_FILL_REQ);
    assign mem_req_write_o = (state_q == ST_WB_REQ);
    assign mem_req_addr_o  = (state_q == ST_WB_REQ)   ? {victim_tag_q, req_index, {L2_OFFSET_WIDTH{1'b0}}} :
                             (state_q == ST_FILL_REQ) ? {req_tag,      req_index, {L2_OFFSET_WIDTH{1'b0}}} : '0;
    assign mem_req_wdata_o = (state_q == ST_WB_REQ) ? victim_data_q : '0;

    l2_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (lookup_ok && lookup_hit),
        .cnt_o (hit_cnt_o)
    );

    l2_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (lookup_ok && !lookup_hit),
        .cnt_o (miss_cnt_o)
    );

endmodule
